// File: rtl/led_pkg.sv
// ============================================================================
// Module      : led_pkg
// Description : Shared types and helpers for the multi-channel LED pattern
//               generator. Optional PWM dimming is enabled by defining the
//               macro LED_PATTERN_PWM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

  // Channel operating mode, encoded exactly as written on the config port.
  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_BURST = 2'd3
  } led_mode_e;

  // Storage widths of the per-channel config record. The record is
  // deliberately wider than the default RATE_W/BURST_W fields. Narrower
  // fields are zero-extended on write, and the constant upper bits are
  // removed by synthesis. RATE_W and BURST_W must not exceed these widths.
  localparam int LED_HALF_MAX_W  = 16;
  localparam int LED_COUNT_MAX_W = 16;

  // Per-channel configuration. While a channel is in BURST, count holds the
  // number of on-pulses still to be produced.
  typedef struct packed {
    led_mode_e                  mode;
    logic [LED_HALF_MAX_W-1:0]  half;
    logic [LED_COUNT_MAX_W-1:0] count;
`ifdef LED_PATTERN_PWM_EN
    logic [7:0]                 duty;
`endif
  } led_cfg_t;

  // Width of the channel-select field. A single channel still needs one bit.
  function automatic int led_ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ============================================================================
// Module      : led_tick_gen
// Description : Base-tick prescaler. It counts 0..DIV-1 and emits a one-cycle
//               registered pulse on each wrap, where
//               DIV = max(1, CLOCK_FREQ_HZ/TICK_HZ).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_tick_gen #(
  parameter int CLOCK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ       = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int DIV_RAW = CLOCK_FREQ_HZ / TICK_HZ;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CNT_W   = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  // Free-running prescaler. The pulse is registered, so the first tick
  // appears DIV cycles after reset is released.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// ============================================================================
// Module      : led_pattern_gen
// Description : NUM_CH independent LED channels (OFF / ON / BLINK / BURST).
//               Channels are configured through a valid/ready write port and
//               timed by a shared base tick.
//               Optional feature: define LED_PATTERN_PWM_EN to add the
//               cfg_duty_i port and per-channel 8-bit PWM dimming.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CLOCK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ       = 1000,
  parameter int RATE_W        = 10,
  parameter int BURST_W       = 4,
  localparam int CH_W         = led_ch_width(NUM_CH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [CH_W-1:0]    cfg_ch_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic [RATE_W-1:0]  cfg_half_i,
  input  logic [BURST_W-1:0] cfg_count_i,
`ifdef LED_PATTERN_PWM_EN
  input  logic [7:0]         cfg_duty_i,
`endif
  output logic               tick_o,
  output logic [NUM_CH-1:0]  busy_o,
  output logic [NUM_CH-1:0]  led_o
);

  logic     ready_q;
  logic     accept;
  logic     tick;
  led_cfg_t wr_cfg;

  // Ready is low only during reset and for the edge that releases it.
  always_ff @(posedge clk_i) begin
    if (rst_i) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  assign cfg_ready_o = ready_q;
  assign accept      = cfg_valid_i & ready_q;

  led_tick_gen #(
    .CLOCK_FREQ_HZ (CLOCK_FREQ_HZ),
    .TICK_HZ       (TICK_HZ)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  assign tick_o = tick;

  // Pack the write port into the storage record shared by all channels.
  always_comb begin
    wr_cfg       = '0;
    wr_cfg.mode  = led_mode_e'(cfg_mode_i);
    wr_cfg.half  = LED_HALF_MAX_W'(cfg_half_i);
    wr_cfg.count = LED_COUNT_MAX_W'(cfg_count_i);
`ifdef LED_PATTERN_PWM_EN
    wr_cfg.duty  = cfg_duty_i;
`endif
  end

`ifdef LED_PATTERN_PWM_EN
  logic [7:0] pwm_cnt;

  // Free-running clock-rate PWM reference shared by all channels.
  always_ff @(posedge clk_i) begin
    if (rst_i) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 8'd1;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_cfg_t                  cfg_q, cfg_d;
    logic [LED_HALF_MAX_W-1:0] phase_q, phase_d;
    logic [LED_HALF_MAX_W-1:0] phase_last;
    logic                      led_q, led_d;
    logic                      wr_hit;
    logic                      is_timed;

    // Channel numbers that do not exist never match, so those writes are dropped.
    assign wr_hit     = accept && (cfg_ch_i == CH_W'(i));
    assign is_timed   = (cfg_q.mode == LED_BLINK) || (cfg_q.mode == LED_BURST);
    // A half-period of zero behaves like one tick.
    assign phase_last = (cfg_q.half == '0) ? '0 : cfg_q.half - LED_HALF_MAX_W'(1);

    // Next state: a config write takes precedence over a tick in the same cycle.
    always_comb begin
      cfg_d   = cfg_q;
      phase_d = phase_q;
      led_d   = led_q;
      if (wr_hit) begin
        cfg_d   = wr_cfg;
        phase_d = '0;
        case (wr_cfg.mode)
          LED_OFF:   led_d = 1'b0;
          LED_ON:    led_d = 1'b1;
          LED_BLINK: led_d = 1'b1;
          LED_BURST: begin
            if (wr_cfg.count == '0) begin
              cfg_d.mode = LED_OFF;
              led_d      = 1'b0;
            end else begin
              led_d      = 1'b1;
            end
          end
          default:   led_d = 1'b0;
        endcase
      end else if (tick && is_timed) begin
        if (phase_q >= phase_last) begin
          phase_d = '0;
          led_d   = ~led_q;
          // Each falling edge completes one burst pulse. The final one
          // returns the channel to OFF on the same edge the LED goes dark.
          if ((cfg_q.mode == LED_BURST) && led_q) begin
            if (cfg_q.count <= LED_COUNT_MAX_W'(1)) begin
              cfg_d.mode  = LED_OFF;
              cfg_d.count = '0;
            end else begin
              cfg_d.count = cfg_q.count - LED_COUNT_MAX_W'(1);
            end
          end
        end else begin
          phase_d = phase_q + LED_HALF_MAX_W'(1);
        end
      end
    end

    // Channel state register.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cfg_q   <= '0;
        phase_q <= '0;
        led_q   <= 1'b0;
      end else begin
        cfg_q   <= cfg_d;
        phase_q <= phase_d;
        led_q   <= led_d;
      end
    end

    assign busy_o[i] = (cfg_q.mode == LED_BURST);
`ifdef LED_PATTERN_PWM_EN
    assign led_o[i]  = led_q & (pwm_cnt < cfg_q.duty);
`else
    assign led_o[i]  = led_q;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Self-checking bench for led_pattern_gen (NUM_CH=4, DIV=10).
//               It runs a directed vector table, multi-cycle sequences and
//               random traffic against a tick-count reference model.
//               LED_PATTERN_PWM_EN is honoured if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_gen;

  localparam int NUM_CH  = 4;
  localparam int DIV     = 10;
  localparam int M_OFF   = 0;
  localparam int M_ON    = 1;
  localparam int M_BLINK = 2;
  localparam int M_BURST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [9:0] cfg_half = '0;
  logic [3:0] cfg_count = '0;
`ifdef LED_PATTERN_PWM_EN
  logic [7:0] cfg_duty = 8'd255;
`endif
  logic       tick;
  logic [3:0] busy;
  logic [3:0] led;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_CH(NUM_CH), .CLOCK_FREQ_HZ(1000), .TICK_HZ(100), .RATE_W(10), .BURST_W(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch), .cfg_mode_i(cfg_mode), .cfg_half_i(cfg_half), .cfg_count_i(cfg_count),
`ifdef LED_PATTERN_PWM_EN
    .cfg_duty_i(cfg_duty),
`endif
    .tick_o(tick), .busy_o(busy), .led_o(led)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: each channel remembers its config and how many ticks it
  // has seen since that write. The outputs follow from that count.
  int m_mode [NUM_CH];
  int m_h    [NUM_CH];
  int m_cnt  [NUM_CH];
  int m_n    [NUM_CH];
  int m_duty [NUM_CH];
  int m_edges;
  int m_pwm;
  bit m_tick;
  bit m_ready;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = M_OFF; m_h[c] = 1; m_cnt[c] = 0; m_n[c] = 0; m_duty[c] = 0;
    end
    m_edges = 0; m_pwm = 0; m_tick = 1'b0; m_ready = 1'b0;
  endfunction

  function automatic void model_out(input int c, output bit l, output bit b);
    int toggles, falls;
    l = 1'b0; b = 1'b0;
    toggles = m_n[c] / m_h[c];
    case (m_mode[c])
      M_ON:    l = 1'b1;
      M_BLINK: l = (toggles % 2) == 0;
      M_BURST: begin
        falls = (toggles + 1) / 2;
        if (falls < m_cnt[c]) begin
          b = 1'b1;
          l = (toggles % 2) == 0;
        end
      end
      default: ;
    endcase
`ifdef LED_PATTERN_PWM_EN
    l = l && (m_pwm < m_duty[c]);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock edge. The model advances and the DUT outputs are compared.
  task automatic step();
    bit acc, l, b;
    logic [3:0] el, eb;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      acc = cfg_valid && m_ready;
      for (int c = 0; c < NUM_CH; c++) begin
        if (acc && (int'(cfg_ch) == c)) begin
          m_mode[c] = (int'(cfg_mode) == M_BURST && cfg_count == 0) ? M_OFF : int'(cfg_mode);
          m_h[c]    = (cfg_half == 0) ? 1 : int'(cfg_half);
          m_cnt[c]  = int'(cfg_count);
          m_n[c]    = 0;
`ifdef LED_PATTERN_PWM_EN
          m_duty[c] = int'(cfg_duty);
`endif
        end else if (m_tick && (m_mode[c] == M_BLINK || m_mode[c] == M_BURST)) begin
          m_n[c]++;
        end
      end
      m_ready = 1'b1;
      m_edges++;
      m_tick  = (m_edges % DIV) == 0;
      m_pwm   = (m_pwm + 1) % 256;
    end
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      model_out(c, l, b);
      el[c] = l; eb[c] = b;
    end
    check("model_cycle", {22'd0, cfg_ready, tick, busy, led}, {22'd0, m_ready, m_tick, eb, el});
  endtask

  task automatic drive(input bit r, input bit v, input int ch, input int mode,
                       input int half, input int count);
    rst = r; cfg_valid = v; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
    cfg_half = 10'(half); cfg_count = 4'(count);
`ifdef LED_PATTERN_PWM_EN
    cfg_duty = 8'd255;
`endif
  endtask

  task automatic wr(input int ch, input int mode, input int half, input int count);
    drive(1'b0, 1'b1, ch, mode, half, count);
    step();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until the model says tick_o is high in the coming cycle (bounded).
  task automatic wait_tick();
    int k;
    k = 0;
    while (!m_tick && k < 3 * DIV) begin
      step();
      k++;
    end
    check("tick_wait", {31'd0, tick}, 32'd1);
  endtask

  typedef struct {
    bit rst; bit valid; int ch; int mode; int half; int count;
    logic [3:0] exp_led; logic [3:0] exp_busy; bit exp_ready; bit exp_tick;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int prev, ntog, pulses, on_len;
    bit last;

    tbl[0]  = '{1, 0, 0, 0,       0, 0, 4'b0000, 4'b0000, 0, 0};
    tbl[1]  = '{1, 0, 0, 0,       0, 0, 4'b0000, 4'b0000, 0, 0};
    tbl[2]  = '{1, 0, 0, 0,       0, 0, 4'b0000, 4'b0000, 0, 0};
    tbl[3]  = '{0, 0, 0, 0,       0, 0, 4'b0000, 4'b0000, 1, 0};
    tbl[4]  = '{0, 1, 0, M_BLINK, 3, 0, 4'b0001, 4'b0000, 1, 0};
    tbl[5]  = '{0, 1, 1, M_BURST, 2, 3, 4'b0011, 4'b0010, 1, 0};
    tbl[6]  = '{0, 1, 3, M_BURST, 2, 0, 4'b0011, 4'b0010, 1, 0};
    tbl[7]  = '{0, 1, 2, M_ON,    0, 0, 4'b0111, 4'b0010, 1, 0};
    tbl[8]  = '{0, 1, 2, M_OFF,   0, 0, 4'b0011, 4'b0010, 1, 0};
    tbl[9]  = '{0, 1, 1, M_ON,    0, 0, 4'b0011, 4'b0000, 1, 0};
    tbl[10] = '{0, 1, 1, M_OFF,   0, 0, 4'b0001, 4'b0000, 1, 0};
    tbl[11] = '{0, 1, 3, M_BURST, 1, 5, 4'b1001, 4'b1000, 1, 0};
    tbl[12] = '{0, 0, 0, 0,       0, 0, 4'b1001, 4'b1000, 1, 1};

    model_reset();

    // Directed vector table starting from reset.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].ch, tbl[i].mode, tbl[i].half, tbl[i].count);
      step();
      check($sformatf("table_%0d", i), {22'd0, cfg_ready, tick, busy, led},
            {22'd0, tbl[i].exp_ready, tbl[i].exp_tick, tbl[i].exp_busy, tbl[i].exp_led});
    end

    // Reset followed by prescaler timing.
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    idle(3);
    check("reset_outputs", {28'd0, cfg_ready, tick, busy != 0, led != 0}, 32'd0);
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    for (int k = 1; k <= 2 * DIV; k++) begin
      step();
      if (k == 1)   check("ready_after_release", {31'd0, cfg_ready}, 32'd1);
      if (k == DIV) check("first_tick", {31'd0, tick}, 32'd1);
      if (k == DIV - 1) check("no_early_tick", {31'd0, tick}, 32'd0);
    end

    // BLINK with half=3 toggles every 30 cycles.
    wr(0, M_BLINK, 3, 0);
    check("blink_on", {31'd0, led[0]}, 32'd1);
    prev = -1; ntog = 0; last = led[0];
    for (int k = 0; k < 200; k++) begin
      step();
      if (led[0] !== last) begin
        if (prev >= 0) check("blink_spacing", cyc - prev, 32'd30);
        prev = cyc; ntog++; last = led[0];
      end
    end
    check("blink_toggle_count", {31'd0, ntog >= 6}, 32'd1);

    // BURST with half=2 and count=3 produces three 20-cycle pulses, then stops.
    wait_tick();
    wr(1, M_BURST, 2, 3);
    check("burst_start", {30'd0, busy[1], led[1]}, 32'd3);
    pulses = 1; on_len = 1; last = 1'b1;
    for (int k = 0; k < 160; k++) begin
      step();
      if (led[1] && last) on_len++;
      if (led[1] && !last) begin pulses++; on_len = 1; end
      if (!led[1] && last) begin
        check("burst_pulse_len", on_len, 32'd20);
        check("burst_busy_at_fall", {31'd0, busy[1]}, {31'd0, pulses < 3});
      end
      last = led[1];
    end
    check("burst_pulses", pulses, 32'd3);

    // A config write in a tick cycle wins over that tick.
    wr(1, M_BURST, 2, 5);
    idle(15);
    wait_tick();
    wr(1, M_OFF, 0, 0);
    check("mid_burst_off", {30'd0, busy[1], led[1]}, 32'd0);
    idle(30);
    wait_tick();
    wr(2, M_BLINK, 1, 0);
    check("blink_h1_on", {31'd0, led[2]}, 32'd1);
    idle(9);
    check("cfg_beats_tick", {31'd0, led[2]}, 32'd1);
    step();
    check("blink_h1_toggle", {31'd0, led[2]}, 32'd0);

    // half=0 behaves as 1. BURST with count=0 behaves as OFF.
    wr(2, M_BLINK, 0, 0);
    idle(40);
    wr(3, M_ON, 0, 0);
    check("ch3_on", {31'd0, led[3]}, 32'd1);
    wr(3, M_BURST, 2, 0);
    check("burst_count0", {30'd0, busy[3], led[3]}, 32'd0);
    idle(20);

    // Reset in the middle of a BURST.
    wr(1, M_BURST, 1, 9);
    idle(15);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    step();
    check("mid_reset_outputs", {22'd0, cfg_ready, tick, busy, led}, 32'd0);
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    step();
    check("ready_after_mid_reset", {31'd0, cfg_ready}, 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3));
`ifdef LED_PATTERN_PWM_EN
      cfg_duty = 8'($urandom_range(0, 255));
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
